// File: rtl/loc_track_mem.sv
// Two-write/two-read location memory with per-entry valid bits, valid count and a one-entry-per-cycle bulk-clear sweep.
// Optional macro LOC_MEM_BYPASS_EN: same-cycle writes are forwarded to reads; otherwise reads see pre-write contents.
module loc_track_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wen_a,
  input  logic             i_wen_b,
  input  logic [DEPTH-1:0] i_waddr_a,
  input  logic [DEPTH-1:0] i_waddr_b,
  input  logic [WIDTH-1:0] i_wdata_a,
  input  logic [WIDTH-1:0] i_wdata_b,
  input  logic             i_ren,
  input  logic [DEPTH-1:0] i_raddr_a,
  input  logic [DEPTH-1:0] i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b,
  output logic             o_hit_a,
  output logic             o_hit_b,
  output logic             o_rvld,
  output logic             o_busy,
  output logic [DEPTH:0]   o_count
);
  localparam int N = 2**DEPTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] sweep_q, sweep_d;
  logic [N-1:0]     valid_q, valid_d;
  logic [DEPTH:0]   count_q, count_d;
  logic             rvld_q;
  logic [1:0]       inc;
  logic             we_a, we_b, rd_en;
  logic [WIDTH-1:0] mem [N];
  logic [DEPTH-1:0] raddr [2];

  // A clear request in IDLE drops any writes presented alongside it
  assign we_a  = i_wen_a && (state_q == IDLE) && !i_clr;
  assign we_b  = i_wen_b && (state_q == IDLE) && !i_clr;
  assign rd_en = i_ren && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    valid_d = valid_q;
    count_d = count_q;
    inc     = '0;
    case (state_q)
      IDLE: begin
        if (i_clr) begin
          state_d = CLEAR;
          valid_d = '0;
          count_d = '0;
        end else begin
          inc = 2'(we_a && !valid_q[i_waddr_a])
              + 2'(we_b && !valid_q[i_waddr_b] && !(we_a && (i_waddr_a == i_waddr_b)));
          if (we_a) valid_d[i_waddr_a] = 1'b1;
          if (we_b) valid_d[i_waddr_b] = 1'b1;
          count_d = count_q + (DEPTH+1)'(inc);
        end
      end
      CLEAR: begin
        sweep_d = sweep_q + DEPTH'(1);
        if (sweep_q == {DEPTH{1'b1}}) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sweep_q <= '0;
      valid_q <= '0;
      count_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      valid_q <= valid_d;
      count_q <= count_d;
      rvld_q  <= rd_en;
    end
  end

  // Data array is never reset; the valid bits mask stale contents
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[sweep_q] <= '0;
    end else begin
      if (we_a) mem[i_waddr_a] <= i_wdata_a;
      if (we_b) mem[i_waddr_b] <= i_wdata_b;
    end
  end

  assign raddr[0] = i_raddr_a;
  assign raddr[1] = i_raddr_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic             hit_d, hit_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
      hit_d  = valid_q[raddr[gi]];
      data_d = mem[raddr[gi]];
`ifdef LOC_MEM_BYPASS_EN
      if (we_a && (i_waddr_a == raddr[gi])) begin
        hit_d  = 1'b1;
        data_d = i_wdata_a;
      end
      if (we_b && (i_waddr_b == raddr[gi])) begin
        hit_d  = 1'b1;
        data_d = i_wdata_b;
      end
`endif
      if (!hit_d) data_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hit_q  <= 1'b0;
        data_q <= '0;
      end else if (rd_en) begin
        hit_q  <= hit_d;
        data_q <= data_d;
      end
    end
  end

  assign o_rdata_a = g_rd[0].data_q;
  assign o_rdata_b = g_rd[1].data_q;
  assign o_hit_a   = g_rd[0].hit_q;
  assign o_hit_b   = g_rd[1].hit_q;
  assign o_rvld    = rvld_q;
  assign o_busy    = (state_q == CLEAR);
  assign o_count   = count_q;

endmodule

// File: tb/tb_loc_track_mem.sv
// Self-checking bench for loc_track_mem: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_loc_track_mem;
  localparam int W = 8;
  localparam int D = 7;
  localparam int N = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_clr = 1'b0, i_wen_a = 1'b0, i_wen_b = 1'b0, i_ren = 1'b0;
  logic [D-1:0] i_waddr_a = '0, i_waddr_b = '0, i_raddr_a = '0, i_raddr_b = '0;
  logic [W-1:0] i_wdata_a = '0, i_wdata_b = '0;
  logic [W-1:0] o_rdata_a, o_rdata_b;
  logic         o_hit_a, o_hit_b, o_rvld, o_busy;
  logic [D:0]   o_count;

  loc_track_mem #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr),
    .i_wen_a(i_wen_a), .i_wen_b(i_wen_b),
    .i_waddr_a(i_waddr_a), .i_waddr_b(i_waddr_b),
    .i_wdata_a(i_wdata_a), .i_wdata_b(i_wdata_b),
    .i_ren(i_ren), .i_raddr_a(i_raddr_a), .i_raddr_b(i_raddr_b),
    .o_rdata_a(o_rdata_a), .o_rdata_b(o_rdata_b),
    .o_hit_a(o_hit_a), .o_hit_b(o_hit_b),
    .o_rvld(o_rvld), .o_busy(o_busy), .o_count(o_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: plain arrays, clear modelled as a count of remaining busy cycles
  logic [W-1:0] m_mem [N];
  bit           m_vld [N];
  int           m_busy_left;
  bit           m_wa, m_wb;
  bit           exp_rvld, exp_hit_a, exp_hit_b;
  logic [W-1:0] exp_data_a, exp_data_b;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_vld[i]) c++;
    return c;
  endfunction

  function automatic void m_read(input logic [D-1:0] ra, output bit hit, output logic [W-1:0] data);
    hit  = m_vld[ra];
    data = m_mem[ra];
`ifdef LOC_MEM_BYPASS_EN
    if (m_wa && i_waddr_a == ra) begin hit = 1'b1; data = i_wdata_a; end
    if (m_wb && i_waddr_b == ra) begin hit = 1'b1; data = i_wdata_b; end
`endif
    if (!hit) data = '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
      m_busy_left = 0;
      exp_rvld = 1'b0; exp_hit_a = 1'b0; exp_hit_b = 1'b0;
      exp_data_a = '0; exp_data_b = '0;
    end else if (m_busy_left > 0) begin
      m_mem[N - m_busy_left] = '0;
      m_busy_left--;
      exp_rvld = 1'b0;
    end else begin
      m_wa = i_wen_a && !i_clr;
      m_wb = i_wen_b && !i_clr;
      exp_rvld = i_ren;
      if (i_ren) begin
        m_read(i_raddr_a, exp_hit_a, exp_data_a);
        m_read(i_raddr_b, exp_hit_b, exp_data_b);
      end
      if (i_clr) begin
        for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        m_busy_left = N;
      end else begin
        if (m_wa) begin m_mem[i_waddr_a] = i_wdata_a; m_vld[i_waddr_a] = 1'b1; end
        if (m_wb) begin m_mem[i_waddr_b] = i_wdata_b; m_vld[i_waddr_b] = 1'b1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rvld",   32'(o_rvld),    32'(exp_rvld));
      chk("busy",   32'(o_busy),    32'(m_busy_left > 0));
      chk("count",  32'(o_count),   32'(m_count()));
      chk("hit_a",  32'(o_hit_a),   32'(exp_hit_a));
      chk("hit_b",  32'(o_hit_b),   32'(exp_hit_b));
      chk("data_a", 32'(o_rdata_a), 32'(exp_data_a));
      chk("data_b", 32'(o_rdata_b), 32'(exp_data_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    i_clr = 1'b0; i_wen_a = 1'b0; i_wen_b = 1'b0; i_ren = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;
    chk("rst_count", 32'(o_count), 0);
    chk("rst_busy",  32'(o_busy),  0);
    chk("rst_rvld",  32'(o_rvld),  0);
    chk("rst_hit_a", 32'(o_hit_a), 0);

    // Write then read back one entry
    i_wen_a = 1'b1; i_waddr_a = 7'd5; i_wdata_a = 8'h3C;
    tick();
    idle_in(); i_ren = 1'b1; i_raddr_a = 7'd5;
    tick();
    idle_in();
    chk("wr_rd_rvld",  32'(o_rvld),    1);
    chk("wr_rd_data",  32'(o_rdata_a), 32'h3C);
    chk("wr_rd_hit",   32'(o_hit_a),   1);
    chk("wr_rd_count", 32'(o_count),   1);
    chk("model_data",  32'(exp_data_a), 32'h3C);

    // Both ports write the same address: B wins, count +1
    i_wen_a = 1'b1; i_waddr_a = 7'd9; i_wdata_a = 8'h11;
    i_wen_b = 1'b1; i_waddr_b = 7'd9; i_wdata_b = 8'h22;
    tick();
    idle_in(); i_ren = 1'b1; i_raddr_b = 7'd9;
    tick();
    idle_in();
    chk("collide_data",  32'(o_rdata_b), 32'h22);
    chk("collide_count", 32'(o_count),   2);
    chk("model_count",   32'(m_count()), 2);

    // Write and read the same address in one cycle
    i_wen_a = 1'b1; i_waddr_a = 7'd4; i_wdata_a = 8'h7F;
    i_ren = 1'b1; i_raddr_a = 7'd4;
    tick();
    idle_in();
`ifdef LOC_MEM_BYPASS_EN
    chk("same_cyc_data", 32'(o_rdata_a), 32'h7F);
    chk("same_cyc_hit",  32'(o_hit_a),   1);
`else
    chk("same_cyc_data", 32'(o_rdata_a), 0);
    chk("same_cyc_hit",  32'(o_hit_a),   0);
`endif
    chk("fill3_count", 32'(o_count), 3);

    // Bulk clear
    i_clr = 1'b1;
    tick();
    idle_in();
    chk("clr_count", 32'(o_count), 0);
    chk("clr_busy",  32'(o_busy),  1);
    n = 0;
    while (o_busy && n < 300) begin
      n++;
      tick();
    end
    chk("clr_cycles", 32'(n), 128);
    i_ren = 1'b1; i_raddr_a = 7'd5; i_raddr_b = 7'd9;
    tick();
    idle_in();
    chk("post_clr_hit_a",  32'(o_hit_a),   0);
    chk("post_clr_hit_b",  32'(o_hit_b),   0);
    chk("post_clr_data_a", 32'(o_rdata_a), 0);
    chk("post_clr_data_b", 32'(o_rdata_b), 0);

    // Reset in the middle of a sweep
    i_wen_a = 1'b1; i_waddr_a = 7'd7; i_wdata_a = 8'h55;
    tick();
    idle_in(); i_ren = 1'b1; i_raddr_a = 7'd7;
    tick();
    idle_in();
    chk("pre_rst_hit", 32'(o_hit_a), 1);
    i_clr = 1'b1;
    tick();
    idle_in();
    repeat (40) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  32'(o_busy),    0);
    chk("abort_count", 32'(o_count),   0);
    chk("abort_hit",   32'(o_hit_a),   0);
    chk("abort_data",  32'(o_rdata_a), 0);
    chk("abort_rvld",  32'(o_rvld),    0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_busy",  32'(o_busy),  0);
    chk("rel_count", 32'(o_count), 0);
    i_wen_b = 1'b1; i_waddr_b = 7'd7; i_wdata_b = 8'h66;
    tick();
    idle_in(); i_ren = 1'b1; i_raddr_a = 7'd7;
    tick();
    idle_in();
    chk("rel_rd_data",  32'(o_rdata_a), 32'h66);
    chk("rel_rd_hit",   32'(o_hit_a),   1);
    chk("rel_rd_count", 32'(o_count),   1);

    // Randomized traffic, narrow address windows force collisions
    for (int k = 0; k < 3000; k++) begin
      bit narrow;
      narrow    = ($urandom_range(0, 1) == 0);
      i_clr     = ($urandom_range(0, 599) == 0);
      i_wen_a   = ($urandom_range(0, 2) != 0);
      i_wen_b   = ($urandom_range(0, 2) != 0);
      i_ren     = ($urandom_range(0, 1) == 0);
      i_waddr_a = narrow ? D'($urandom_range(0, 7)) : D'($urandom);
      i_waddr_b = narrow ? D'($urandom_range(0, 7)) : D'($urandom);
      i_raddr_a = narrow ? D'($urandom_range(0, 7)) : D'($urandom);
      i_raddr_b = narrow ? D'($urandom_range(0, 7)) : D'($urandom);
      i_wdata_a = W'($urandom);
      i_wdata_b = W'($urandom);
      tick();
    end
    idle_in();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
